// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  fetch_stage : owns the PC, reads the program ROM, hands words to decode.
//  Rev 1.0     : initial release
// ============================================================================
module fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              CLK,
   input  logic              RST,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);

   localparam logic [0:0] S_RUN    = 1'b0;
   localparam logic [0:0] S_HALTED = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              slot_free;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_RUN;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect)
         state_d = S_RUN;
      else if (state_q == S_RUN && halt)
         state_d = S_HALTED;
   end

   assign slot_free = ~instr_valid_q | instr_ready;

   // A word being taken this cycle still completes; the flush only clears what follows.
   always_comb begin
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      if (redirect) begin
         pc_d          = redirect_pc;
         instr_valid_d = 1'b0;
      end else if (state_q == S_RUN && !halt && slot_free) begin
         instr_d       = rom_data;
         instr_pc_d    = pc_q;
         instr_valid_d = 1'b1;
         pc_d          = pc_q + ADDR_W'(1);
      end else if (state_q == S_HALTED || halt) begin
         instr_valid_d = instr_valid_q & ~instr_ready;
      end
   end

   always_comb begin
      halted      = (state_q == S_HALTED);
      rom_address = pc_q;
      instr       = instr_q;
      instr_pc    = instr_pc_q;
      instr_valid = instr_valid_q;
   end

endmodule
`default_nettype wire
